// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-128 round controller.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } aes_state_e;

    localparam int AES128_NR = 10;
    localparam int ROUND_W   = 4;

endpackage

// File: rtl/aes_round_counter.sv
// Round / in-round cycle counter pair; cyc wraps after ROUND_LAT-1 and advances the round.
module aes_round_counter
    import aes_pkg::*;
#(
    parameter int NR        = AES128_NR,
    parameter int ROUND_LAT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               load,
    input  logic               step,
    output logic [ROUND_W-1:0] round,
    output logic [ROUND_W-1:0] cyc,
    output logic               last_cyc,
    output logic               last_round
);

    localparam logic [ROUND_W-1:0] LAST_CYC   = ROUND_W'(ROUND_LAT - 1);
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NR);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            round <= '0;
            cyc   <= '0;
        end else if (load) begin
            round <= ROUND_W'(1);
            cyc   <= '0;
        end else if (step) begin
            if (last_cyc) begin
                cyc   <= '0;
                round <= round + 1'b1;
            end else begin
                cyc <= cyc + 1'b1;
            end
        end
    end

    assign last_cyc   = (cyc == LAST_CYC);
    assign last_round = (round == LAST_ROUND);

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencing controller for the iterative AES-128 datapath; Moore outputs decoded
// from the registered state and counters only.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR        = AES128_NR,
    parameter int ROUND_LAT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic               flush_i,
    output logic               load_o,
    output logic               dp_en_o,
    output logic               key_step_o,
    output logic               state_we_o,
    output logic               mc_bypass_o,
    output logic [ROUND_W-1:0] round_o,
    output logic               out_valid_o,
    input  logic               out_ready_i
);

    aes_state_e         state_q;
    aes_state_e         state_d;
    logic               cnt_clear;
    logic               cnt_load;
    logic               cnt_step;
    logic [ROUND_W-1:0] round;
    logic [ROUND_W-1:0] cyc;
    logic               last_cyc;
    logic               last_round;

    aes_round_counter #(
        .NR        (NR),
        .ROUND_LAT (ROUND_LAT)
    ) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (cnt_clear),
        .load       (cnt_load),
        .step       (cnt_step),
        .round      (round),
        .cyc        (cyc),
        .last_cyc   (last_cyc),
        .last_round (last_round)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_load  = 1'b0;
        cnt_step  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                cnt_load = 1'b1;
                state_d  = ROUND;
            end
            ROUND: begin
                // Counters freeze on the final write-back so DONE keeps a stable view.
                if (last_cyc && last_round) begin
                    state_d = DONE;
                end else begin
                    cnt_step = 1'b1;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d   = IDLE;
                    cnt_clear = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_clear = 1'b1;
            end
        endcase
        // Abort outranks every handshake, including a same-cycle acceptance.
        if (flush_i) begin
            state_d   = IDLE;
            cnt_clear = 1'b1;
            cnt_load  = 1'b0;
            cnt_step  = 1'b0;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign load_o      = (state_q == INIT);
    assign dp_en_o     = (state_q == INIT) || (state_q == ROUND);
    assign key_step_o  = (state_q == ROUND) && (cyc == '0);
    assign state_we_o  = (state_q == ROUND) && last_cyc;
    assign mc_bypass_o = (state_q == ROUND) && last_round;
    assign round_o     = (state_q == ROUND) ? round : '0;
    assign out_valid_o = (state_q == DONE);

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Sequencing controller for the iterative AES-128 encryption datapath: SubBytes, ShiftRows, MixColumns, AddRoundKey and the round-key expander. It accepts a block through a valid/ready handshake and issues the initial key load. It then steps the datapath through NR rounds of ROUND_LAT cycles each, bypassing MixColumns in the final round, and presents completion through an output valid/ready handshake. It contains no data path; it drives only control strobes into the existing round logic.

## Interface
- NR, 10: number of AES rounds (10 for AES-128); legal 1..15
- ROUND_LAT, 3: datapath cycles per round (registered stages between state-register write-backs); legal 1..15
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid_i  in  1  new block (plaintext + key) presented to datapath
- in_ready_o  out  1  controller idle, block accepted when in_valid_i && in_ready_o
- flush_i  in  1  synchronous abort of any operation in progress
- load_o  out  1  select plaintext^key into state register; key expander loads cipher key
- dp_en_o  out  1  enable for registered datapath stages (MixColumns et al. clear their output when low)
- key_step_o  out  1  advance key expander to next round key
- state_we_o  out  1  write round result back into state register
- mc_bypass_o  out  1  final round: route ShiftRows output around MixColumns
- round_o  out  4  current round number, 0 in IDLE/INIT, 1..NR in ROUND
- out_valid_o  out  1  ciphertext in state register valid
- out_ready_i  in  1  consumer accepts ciphertext

## Operation
- States: IDLE, INIT, ROUND, DONE (enum in shared package).
- IDLE: in_ready_o=1; all strobes 0. Handshake -> INIT.
- INIT (1 cycle): load_o=1, dp_en_o=1, round counter set to 1, cycle counter to 0 -> ROUND.
- ROUND: dp_en_o=1; round_o = round counter; key_step_o=1 when cyc==0; state_we_o=1 when cyc==ROUND_LAT-1; mc_bypass_o=1 throughout round NR.
  - cyc increments each cycle, wraps to 0 after ROUND_LAT-1 and round increments.
  - state_we_o in round NR -> DONE.
- DONE: out_valid_o=1, held stable until out_ready_i=1 -> IDLE. dp_en_o=0; the state register holds the result.
- flush_i=1 in any state: next state IDLE, counters cleared. No strobe is asserted in the cycle after flush. flush_i has priority over all other inputs, including a same-cycle in_valid_i handshake and out_ready_i.
- in_valid_i while not IDLE: ignored (in_ready_o=0); no back-to-back acceptance from DONE.
- ROUND_LAT=1: key_step_o and state_we_o are both high every ROUND cycle.
- Counters: round 4 bits, cyc 4 bits; no overflow within legal parameter range.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, counters 0. All outputs 0 except in_ready_o=1. Reset mid-operation discards the block and emits no out_valid_o.
- All outputs are decoded from registered state/counters only (Moore). No combinational path from inputs to outputs except none: in_ready_o depends only on state.
- Handshake edge = cycle 0. INIT in cycle 1. Round r occupies cycles 2+(r-1)*ROUND_LAT .. 1+r*ROUND_LAT. out_valid_o first high in cycle 2+NR*ROUND_LAT (32 for defaults).
- Next handshake possible earliest one cycle after out_ready_i is sampled high in DONE.

## Structure
- Shared package aes_pkg: state enum type, AES128_NR=10, round-width constant (4).
- Single module. The round/cycle counter pair may be split into sub-module aes_round_counter (inputs clear, step; outputs round, cyc, last_cyc, last_round); otherwise flat.

## Test plan
- Reset then single block, defaults: in_valid_i=1 at cycle 0 -> load_o at cycle 1; key_step_o at cycles 2,5,…,29; state_we_o at 4,7,…,31; mc_bypass_o during cycles 29-31; out_valid_o at 32.
- Backpressure: out_ready_i=0 for 5 cycles in DONE -> out_valid_o held 5+ cycles, in_ready_o=0, in_valid_i ignored; release -> IDLE next cycle.
- Flush in round 4 (cycle 12) -> cycle 13 IDLE, in_ready_o=1, no state_we_o/out_valid_o; new block then completes normally in 32 cycles.
- ROUND_LAT=1, NR=10: key_step_o and state_we_o high cycles 2..11, out_valid_o at cycle 12.
- Reset asserted mid-round 7 -> next cycle all outputs 0, in_ready_o=1, round_o=0.
- flush_i and in_valid_i together in IDLE -> no acceptance, remain IDLE, load_o stays 0.
